// File: rtl/sys_time_sync_pkg.sv
// rtl/sys_time_sync_pkg.sv - shared types and widths for system time synchronisation
package sys_time_sync_pkg;

  localparam int SYS_TIME_W = 64;
  localparam int DRIFT_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    WAIT_BND
  } sync_state_t;

  typedef logic [SYS_TIME_W-1:0] sys_time_t;

endpackage

// File: rtl/sys_time_sync_sat_sub.sv
// rtl/sys_time_sync_sat_sub.sv - signed 64-bit subtract saturated into a signed 32-bit result
module sat_sub_s64_to_s32
  import sys_time_sync_pkg::*;
(
  input  sys_time_t          a,
  input  sys_time_t          b,
  output logic [DRIFT_W-1:0] y
);

  sys_time_t diff;
  logic      all_ones;
  logic      any_ones;

  assign diff = a - b;

  // The result fits only when every bit above the output sign bit matches the 64-bit sign.
  assign all_ones = &diff[SYS_TIME_W-2:DRIFT_W-1];
  assign any_ones = |diff[SYS_TIME_W-2:DRIFT_W-1];

  always_comb begin
    y = diff[DRIFT_W-1:0];
    if (!diff[SYS_TIME_W-1] && any_ones) begin
      y = {1'b0, {(DRIFT_W-1){1'b1}}};
    end else if (diff[SYS_TIME_W-1] && !all_ones) begin
      y = {1'b1, {(DRIFT_W-1){1'b0}}};
    end
  end

endmodule

// File: rtl/sys_time_sync.sv
// rtl/sys_time_sync.sv - offset-adjusted system time with period-aligned offset updates
// Optional drift output enabled by defining SYS_TIME_SYNC_DRIFT_EN.
module sys_time_sync
  import sys_time_sync_pkg::*;
#(
  parameter int WIDTH  = SYS_TIME_W,
  parameter int PERIOD = 512,
  parameter int CNT_W  = $clog2(PERIOD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               locked,
  input  logic [WIDTH-1:0]   sys_time,
  input  logic               sync_valid,
  input  logic [WIDTH-1:0]   sync_time,
  output logic               sync_ready,
  output logic               sync_done,
  output logic [WIDTH-1:0]   sys_time_adj,
  output logic [CNT_W-1:0]   time_cnt,
`ifdef SYS_TIME_SYNC_DRIFT_EN
  output logic [DRIFT_W-1:0] drift,
`endif
  output logic               update
);

  if (PERIOD < 2 || (PERIOD & (PERIOD - 1)) != 0) begin : g_bad_period
    $error("sys_time_sync: PERIOD must be a power of two and at least 2");
  end

  sync_state_t      state;
  sync_state_t      state_nxt;
  logic [WIDTH-1:0] offset_cur;
  logic [WIDTH-1:0] offset_new;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sys_q;
  logic [WIDTH-1:0] adj_sum;
  logic             accept;
  logic             calc_en;
  logic             fire;

  assign adj_sum  = sys_time + offset_cur;
  assign time_cnt = sys_time_adj[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sync_ready = 1'b0;
    accept     = 1'b0;
    calc_en    = 1'b0;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        // Ready is gated by rst_n so it reads 0 while reset is held.
        sync_ready = locked && rst_n;
        if (sync_valid && locked && rst_n) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        calc_en   = 1'b1;
        state_nxt = WAIT_BND;
      end
      WAIT_BND: begin
        if (time_cnt == CNT_W'(PERIOD - 1)) begin
          fire      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!locked) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      calc_en   = 1'b0;
      fire      = 1'b0;
    end
  end

  // The boundary edge still loads with the old offset; the new one applies from the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_time_adj <= '0;
      update       <= 1'b0;
      sync_done    <= 1'b0;
      offset_cur   <= '0;
      offset_new   <= '0;
      sync_q       <= '0;
      sys_q        <= '0;
    end else if (locked) begin
      sys_time_adj <= adj_sum;
      update       <= (adj_sum[CNT_W-1:0] == '0);
      sync_done    <= fire;
      if (accept) begin
        sync_q <= sync_time;
        sys_q  <= sys_time;
      end
      if (calc_en) begin
        offset_new <= sync_q - sys_q;
      end
      if (fire) begin
        offset_cur <= offset_new;
      end
    end else begin
      sync_done <= 1'b0;
    end
  end

`ifdef SYS_TIME_SYNC_DRIFT_EN
  if (WIDTH != SYS_TIME_W) begin : g_bad_width
    $error("sys_time_sync: drift output requires WIDTH == SYS_TIME_W");
  end

  logic [DRIFT_W-1:0] drift_sat;

  sat_sub_s64_to_s32 u_sat_sub (
    .a (offset_new),
    .b (offset_cur),
    .y (drift_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drift <= '0;
    end else if (fire) begin
      drift <= drift_sat;
    end
  end
`endif

endmodule
